lc3_instr_encoder: RTL and testbench
====================================

Name: lc3_instr_encoder

Overview:
- Packs assembler-level operands into a 16-bit LC-3 instruction word; the inverse of the datapath's field-extraction/sign-extension path.
- Narrows 16-bit immediates and offsets into imm5, offset6, PCoffset9, PCoffset11 and trapvect8, and range-checks each one.
- Sits between the debug/loader front-end and the memory write port.
- Two-stage valid/ready pipeline with back-pressure.

Parameters:
PCREL_BIAS, 1, constant added to in_pc before computing a PC-relative offset (offset = value - (pc + PCREL_BIAS)).
CHECK_RANGE, 1, when 0 the range errors are suppressed; field truncation is unchanged.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  encoder accepts operand set
in_op  input  4  LC-3 opcode [15:12]
in_r0  input  3  DR/SR, or nzp for BR
in_r1  input  3  SR1/BaseR
in_r2  input  3  SR2
in_imm_mode  input  1  ADD/AND: immediate form; JSR: PCoffset11 form
in_pcrel  input  1  in_value is an absolute target; convert to a PC-relative offset
in_value  input  16  immediate, offset or target address
in_pc  input  16  address of the instruction being encoded
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts the word
out_instr  output  16  encoded instruction
out_err  output  2  00 ok, 01 field out of range, 10 reserved opcode

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0x0000, out_err=00, in_ready=1 after reset deasserts.
- Advance enable: adv = !out_valid | out_ready.
- in_ready = adv | !s1_valid. A transfer occurs when in_valid & in_ready.
- Stage 1 (registered):
  - Captures the operands.
  - For PC-offset opcodes (BR, LD, ST, LDI, STI, LEA, JSR with imm_mode=1) with in_pcrel=1: off = in_value - (in_pc + PCREL_BIAS), modulo 2^16.
  - Otherwise off = in_value.
- Stage 2 (registered, drives the outputs): packs the fields and evaluates the range check. Latency from accept to out_valid is 2 cycles, throughput 1 word/cycle.
- Signed N-bit fit rule: off[15:N-1] all equal. The field is always off[N-1:0], even when the check fails.
- Encoding per opcode:
  - BR 0000: nzp=r0, PCoffset9.
  - ADD 0001 / AND 0101: DR=r0, SR1=r1. imm_mode=1 gives bit5=1 and imm5; imm_mode=0 gives bits[5:3]=000 and SR2=r2.
  - LD 0010, ST 0011, LDI 1010, STI 1011, LEA 1110: r0 and PCoffset9.
  - JSR 0100: imm_mode=1 gives bit11=1 and PCoffset11; imm_mode=0 gives 0100 000 r1 000000 (JSRR).
  - LDR 0110 / STR 0111: r0, r1, offset6.
  - NOT 1001: r0, r1, bits[5:0]=111111.
  - RTI 1000: 0x8000.
  - JMP 1100: 1100 000 r1 000000.
  - TRAP 1111: trapvect8 is unsigned; fits iff off[15:8]==0.
  - Reserved 1101: out_instr=0xD000, err=10.
- Error precedence: 10 over 01. With CHECK_RANGE=0, err is never 01.
- Stall: while out_valid & !out_ready, out_instr and out_err hold stable and stage 1 holds. A new input is accepted only if stage 1 is empty.
- Simultaneous out_ready and in_valid with a full pipe: both stages shift and the new word is accepted in the same cycle; no bubble.
- Order is always preserved; no drop, no duplicate.
- Reset mid-stall discards all in-flight words.
- Offset arithmetic wraps modulo 2^16, e.g. pc=0xFFFF, target=0x0000 gives off=0x0000.

Decomposition:
- Shared package lc3_pkg: opcode localparams (OP_BR..OP_TRAP), error codes ERR_OK/ERR_RANGE/ERR_RSVD, field widths (5, 6, 9, 11, 8).
- One sub-module: lc3_field_narrow, parameterised by width N and a SIGNED flag. It is combinational, outputs field[N-1:0] and fits, and is instantiated once per field width in stage 2.

Test Plan:
- ADD R1,R2,#-3 (op=1, r0=1, r1=2, imm_mode=1, value=0xFFFD) -> out_instr=0x12BD, err=00, out_valid exactly 2 cycles after accept.
- BRnzp, r0=7, pcrel=1, pc=0x3000, value=0x3000 -> off=-1, out_instr=0x0FFF, err=00. LD r0=0, pc=0x3000, target=0x3200 -> out_instr=0x21FF, err=01.
- LDR R3,R4,#31 (value=0x001F) -> 0x671F, err=00. Value 0x0020 -> 0x6720, err=01. Value 0xFFE0 -> 0x6720, err=00.
- TRAP value=0x0025 -> 0xF025, err=00. Value=0x0125 -> 0xF025, err=01. Op=1101 -> 0xD000, err=10.
- Stream ADD/AND/NOT/JMP/JSR/JSRR back-to-back, out_ready low for 4 cycles -> in_ready drops once both stages are full, outputs held stable, all 6 words emerge in order with no bubble after out_ready rises.
- Assert reset while stalled with 2 words in flight -> out_valid=0 and out_instr=0x0000 immediately. After release, the next input emerges first.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 encoding constants: opcodes, error codes, field widths,
// the stage-1 operand bundle, and the PC-offset opcode classifier.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RSVD = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_RSVD  = 2'b10;

  localparam int W_IMM5  = 5;
  localparam int W_OFF6  = 6;
  localparam int W_OFF9  = 9;
  localparam int W_OFF11 = 11;
  localparam int W_TRAP8 = 8;

  // Operand set held in stage 1; off is already PC-relative where needed.
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        imm_mode;
    logic [15:0] off;
  } operands_t;

  // True for opcodes whose value field is a PC-relative offset.
  function automatic logic is_pc_offset(input logic [3:0] op, input logic imm_mode);
    case (op)
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: is_pc_offset = 1'b1;
      OP_JSR:                                      is_pc_offset = imm_mode;
      default:                                     is_pc_offset = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc3_field_narrow.sv
// Narrows a 16-bit value to an N-bit instruction field and reports whether
// the value is representable (signed two's complement or unsigned).
module lc3_field_narrow #(
  parameter int N      = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic [15:0]  value,
  output logic [N-1:0] field,
  output logic         fits
);

  assign field = value[N-1:0];

  if (SIGNED) begin : g_signed
    // Signed fit: every bit from the MSB down to the field's sign bit agrees.
    assign fits = (&value[15:N-1]) | ~(|value[15:N-1]);
  end else begin : g_unsigned
    // Unsigned fit: nothing set above the field.
    assign fits = ~(|value[15:N]);
  end

endmodule

// File: rtl/lc3_instr_encoder.sv
// Two-stage LC-3 instruction encoder. Stage 1 captures operands and forms
// PC-relative offsets; stage 2 packs fields, range-checks them and drives
// the output handshake. Both stages advance together under back-pressure.
module lc3_instr_encoder
  import lc3_pkg::*;
#(
  parameter logic [15:0] PCREL_BIAS  = 16'd1,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_r0,
  input  logic [2:0]  in_r1,
  input  logic [2:0]  in_r2,
  input  logic        in_imm_mode,
  input  logic        in_pcrel,
  input  logic [15:0] in_value,
  input  logic [15:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [1:0]  out_err
);

  logic        adv;
  logic        take;
  logic        s1_valid;
  operands_t   s1;
  operands_t   s1_next;
  logic [15:0] pcrel_off;

  logic [W_IMM5-1:0]  imm5;
  logic [W_OFF6-1:0]  off6;
  logic [W_OFF9-1:0]  off9;
  logic [W_OFF11-1:0] off11;
  logic [W_TRAP8-1:0] trap8;
  logic               imm5_fits;
  logic               off6_fits;
  logic               off9_fits;
  logic               off11_fits;
  logic               trap8_fits;

  logic [15:0] pack_instr;
  logic [1:0]  pack_err;
  logic        range_ok;

  // The output register can take a new word when empty or being drained;
  // stage 1 can take a new operand set when it advances or is empty.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;
  assign take     = in_valid && in_ready;

  // Wraps modulo 2^16 through the 16-bit assignment width.
  assign pcrel_off = in_value - (in_pc + PCREL_BIAS);

  // Build the next stage-1 operand bundle from the input port.
  always_comb begin
    s1_next          = '0;
    s1_next.op       = in_op;
    s1_next.r0       = in_r0;
    s1_next.r1       = in_r1;
    s1_next.r2       = in_r2;
    s1_next.imm_mode = in_imm_mode;
    s1_next.off      = (in_pcrel && is_pc_offset(in_op, in_imm_mode)) ? pcrel_off : in_value;
  end

  // Stage 1 register: load on accept, empty out when drained into stage 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (take) begin
      s1_valid <= 1'b1;
      s1       <= s1_next;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  lc3_field_narrow #(.N(W_IMM5),  .SIGNED(1'b1)) u_imm5  (.value(s1.off), .field(imm5),  .fits(imm5_fits));
  lc3_field_narrow #(.N(W_OFF6),  .SIGNED(1'b1)) u_off6  (.value(s1.off), .field(off6),  .fits(off6_fits));
  lc3_field_narrow #(.N(W_OFF9),  .SIGNED(1'b1)) u_off9  (.value(s1.off), .field(off9),  .fits(off9_fits));
  lc3_field_narrow #(.N(W_OFF11), .SIGNED(1'b1)) u_off11 (.value(s1.off), .field(off11), .fits(off11_fits));
  lc3_field_narrow #(.N(W_TRAP8), .SIGNED(1'b0)) u_trap8 (.value(s1.off), .field(trap8), .fits(trap8_fits));

  // Pack the instruction word and classify errors; reserved beats range.
  always_comb begin
    pack_instr = 16'h0000;
    pack_err   = ERR_OK;
    range_ok   = 1'b1;
    case (s1.op)
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin
        pack_instr = {s1.op, s1.r0, off9};
        range_ok   = off9_fits;
      end
      OP_ADD, OP_AND: begin
        if (s1.imm_mode) begin
          pack_instr = {s1.op, s1.r0, s1.r1, 1'b1, imm5};
          range_ok   = imm5_fits;
        end else begin
          pack_instr = {s1.op, s1.r0, s1.r1, 3'b000, s1.r2};
        end
      end
      OP_JSR: begin
        if (s1.imm_mode) begin
          pack_instr = {s1.op, 1'b1, off11};
          range_ok   = off11_fits;
        end else begin
          pack_instr = {s1.op, 3'b000, s1.r1, 6'b000000};
        end
      end
      OP_LDR, OP_STR: begin
        pack_instr = {s1.op, s1.r0, s1.r1, off6};
        range_ok   = off6_fits;
      end
      OP_NOT:  pack_instr = {s1.op, s1.r0, s1.r1, 6'b111111};
      OP_RTI:  pack_instr = 16'h8000;
      OP_JMP:  pack_instr = {s1.op, 3'b000, s1.r1, 6'b000000};
      OP_TRAP: begin
        pack_instr = {s1.op, 4'b0000, trap8};
        range_ok   = trap8_fits;
      end
      default: begin
        pack_instr = 16'hD000;
        pack_err   = ERR_RSVD;
      end
    endcase
    if (pack_err == ERR_OK && CHECK_RANGE && !range_ok) begin
      pack_err = ERR_RANGE;
    end
  end

  // Stage 2 / output register: holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= 16'h0000;
      out_err   <= ERR_OK;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pack_instr;
        out_err   <= pack_err;
      end
    end
  end

endmodule

// File: tb/tb_lc3_instr_encoder.sv
// Self-checking bench for lc3_instr_encoder: expected words are pushed to a
// scoreboard queue when the encoder accepts an operand set and popped when
// the encoder hands a word to the consumer.
module tb_lc3_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_r0;
  logic [2:0]  in_r1;
  logic [2:0]  in_r2;
  logic        in_imm_mode;
  logic        in_pcrel;
  logic [15:0] in_value;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [1:0]  out_err;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        imm;
    logic        pcrel;
    logic [15:0] value;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [1:0]  err;
  } item_t;

  exp_t sb[$];

  lc3_instr_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2),
    .in_imm_mode(in_imm_mode), .in_pcrel(in_pcrel),
    .in_value(in_value), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic item_t mk(input logic [3:0] op, input logic [2:0] r0, input logic [2:0] r1,
                               input logic [2:0] r2, input logic imm, input logic pcrel,
                               input logic [15:0] value, input logic [15:0] pc,
                               input logic [15:0] instr, input logic [1:0] err);
    item_t it;
    it.op = op; it.r0 = r0; it.r1 = r1; it.r2 = r2; it.imm = imm; it.pcrel = pcrel;
    it.value = value; it.pc = pc; it.instr = instr; it.err = err;
    return it;
  endfunction

  task automatic drive_item(input item_t it);
    in_op       = it.op;
    in_r0       = it.r0;
    in_r1       = it.r1;
    in_r2       = it.r2;
    in_imm_mode = it.imm;
    in_pcrel    = it.pcrel;
    in_value    = it.value;
    in_pc       = it.pc;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive_item(mk(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b00));
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_instr !== 16'h0000) begin n_fails++; $display("[TB] FAIL reset_out_instr: got %h expected 0000", out_instr); end
    n_checks++;
    if (out_err !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_out_err: got %b expected 00", out_err); end
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_latency;
    exp_t e;
    @(negedge clk);
    drive_item(mk(4'h1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0, 16'hFFFD, 16'h0000, 16'h12BD, 2'b00));
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL add_accept: in_ready got %b expected 1", in_ready); end
    sb.push_back('{instr: 16'h12BD, err: 2'b00});
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL add_latency_early: out_valid got %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fails++; $display("[TB] FAIL add_latency: out_valid got %b expected 1", out_valid);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (out_instr !== e.instr) begin n_fails++; $display("[TB] FAIL add_instr: got %h expected %h", out_instr, e.instr); end
      n_checks++;
      if (out_err !== e.err) begin n_fails++; $display("[TB] FAIL add_err: got %b expected %b", out_err, e.err); end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL add_drained: out_valid got %b expected 0", out_valid); end
    sb.delete();
  endtask

  task automatic test_fields;
    item_t t[11];
    exp_t  e;
    int    idx = 0;
    int    got = 0;
    t[0]  = mk(4'h0, 3'd7, 3'd0, 3'd0, 1'b0, 1'b1, 16'h3000, 16'h3000, 16'h0FFF, 2'b00);
    t[1]  = mk(4'h2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h3200, 16'h3000, 16'h21FF, 2'b01);
    t[2]  = mk(4'h6, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 16'h001F, 16'h0000, 16'h671F, 2'b00);
    t[3]  = mk(4'h6, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h6720, 2'b01);
    t[4]  = mk(4'h6, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 16'hFFE0, 16'h0000, 16'h6720, 2'b00);
    t[5]  = mk(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0025, 16'h0000, 16'hF025, 2'b00);
    t[6]  = mk(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0125, 16'h0000, 16'hF025, 2'b01);
    t[7]  = mk(4'hD, 3'd5, 3'd5, 3'd5, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'hD000, 2'b10);
    t[8]  = mk(4'h0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0400, 2'b00);
    t[9]  = mk(4'h8, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h8000, 2'b00);
    t[10] = mk(4'h3, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h3B00, 2'b01);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 11; cyc++) begin
      @(negedge clk);
      if (idx < 11) begin drive_item(t[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++; $display("[TB] FAIL fields_extra: unexpected word %h", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_instr !== e.instr) begin n_fails++; $display("[TB] FAIL fields_instr[%0d]: got %h expected %h", got, out_instr, e.instr); end
          n_checks++;
          if (out_err !== e.err) begin n_fails++; $display("[TB] FAIL fields_err[%0d]: got %b expected %b", got, out_err, e.err); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{instr: t[idx].instr, err: t[idx].err});
        idx++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 11) begin n_fails++; $display("[TB] FAIL fields_timeout: got %0d words expected 11", got); end
    sb.delete();
  endtask

  task automatic test_back_to_back;
    item_t t[6];
    exp_t  e;
    int    idx = 0;
    int    got = 0;
    int    first_pop = -1;
    int    last_pop = -1;
    t[0] = mk(4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1283, 2'b00);
    t[1] = mk(4'h5, 3'd4, 3'd5, 3'd0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h5965, 2'b00);
    t[2] = mk(4'h9, 3'd6, 3'd7, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h9DFF, 2'b00);
    t[3] = mk(4'hC, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC1C0, 2'b00);
    t[4] = mk(4'h4, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 16'h3010, 16'h3000, 16'h480F, 2'b00);
    t[5] = mk(4'h4, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h40C0, 2'b00);
    for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      if (idx < 6) begin drive_item(t[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (cyc == 2 || cyc == 3) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_stall_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_stall_valid[%0d]: got %b expected 1", cyc, out_valid); end
        n_checks++;
        if (out_instr !== 16'h1283) begin n_fails++; $display("[TB] FAIL b2b_stall_hold[%0d]: got %h expected 1283", cyc, out_instr); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++; $display("[TB] FAIL b2b_extra: unexpected word %h", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_instr !== e.instr) begin n_fails++; $display("[TB] FAIL b2b_instr[%0d]: got %h expected %h", got, out_instr, e.instr); end
          n_checks++;
          if (out_err !== e.err) begin n_fails++; $display("[TB] FAIL b2b_err[%0d]: got %b expected %b", got, out_err, e.err); end
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{instr: t[idx].instr, err: t[idx].err});
        idx++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 6) begin n_fails++; $display("[TB] FAIL b2b_timeout: got %0d words expected 6", got); end
    n_checks++;
    if (first_pop != 4 || last_pop - first_pop != 5) begin
      n_fails++; $display("[TB] FAIL b2b_no_bubble: pops at cycles %0d..%0d expected 4..9", first_pop, last_pop);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_stall;
    item_t t[2];
    item_t lea;
    exp_t  e;
    int    idx = 0;
    int    got = 0;
    t[0] = mk(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0025, 16'h0000, 16'hF025, 2'b00);
    t[1] = mk(4'h1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0, 16'hFFFD, 16'h0000, 16'h12BD, 2'b00);
    lea  = mk(4'hE, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h3005, 16'h3000, 16'hE404, 2'b00);
    for (int cyc = 0; cyc < 10 && idx < 2; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive_item(t[idx]); in_valid = 1'b1;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back('{instr: t[idx].instr, err: t[idx].err});
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || idx != 2) begin n_fails++; $display("[TB] FAIL rst_stall_setup: out_valid %b accepted %0d expected 1 and 2", out_valid, idx); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_stall_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_instr !== 16'h0000) begin n_fails++; $display("[TB] FAIL rst_stall_instr: got %h expected 0000", out_instr); end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 1; cyc++) begin
      @(negedge clk);
      if (idx < 3) begin drive_item(lea); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++; $display("[TB] FAIL rst_after_extra: unexpected word %h", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_instr !== e.instr) begin n_fails++; $display("[TB] FAIL rst_after_instr: got %h expected %h", out_instr, e.instr); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{instr: lea.instr, err: lea.err});
        idx++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 1) begin n_fails++; $display("[TB] FAIL rst_after_timeout: got %0d words expected 1", got); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_after_stale: out_valid got %b expected 0", out_valid); end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_fields();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
